// File: rtl/spi_reg_slave_if.sv
// Register-bank side of spi_reg_slave: address, write data/strobe, read strobe/data.
`timescale 1ns/1ps
interface spi_reg_slave_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_write;
  logic              reg_read;
  logic [DATA_W-1:0] reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_write, reg_read, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_write, reg_read, output reg_rdata);
endinterface

// File: rtl/spi_reg_slave.sv
// SPI (mode 0/3) slave bridging to a register bank, fully in the clk domain.
// Define SPI_REG_BURST_EN for auto-incrementing multi-word bursts; otherwise one word per frame.
`timescale 1ns/1ps
module spi_reg_slave #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int CPOL        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_sclk,
  input  logic            spi_mosi,
  input  logic            spi_cs_n,
  output logic            spi_miso,
  output logic            spi_miso_oe,
  spi_reg_slave_if.master bus,
  output logic            busy,
  output logic            frame_err
);
  localparam int HDR_LEN = 1 + ADDR_W;
  localparam int SH_W    = (HDR_LEN > DATA_W) ? HDR_LEN : DATA_W;
  localparam int CNT_W   = $clog2(SH_W);

  typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_d;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   rise, fall;
  logic                   hdr_last, word_last, abort;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SH_W-1:0]        rx_shift;
  logic [DATA_W-1:0]      tx_shift;
  logic [HDR_LEN-1:0]     hdr_word;
  logic [DATA_W-1:0]      rx_word;
  logic                   rd_pend;

  // sclk chain resets to the idle level so neither reset nor CS assertion looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{1'(CPOL)}};
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'(CPOL);
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign busy   = ~cs_s;

  assign rise = ~cs_s & sclk_s & ~sclk_d;
  assign fall = ~cs_s & ~sclk_s & sclk_d;

  assign hdr_word  = {rx_shift[HDR_LEN-2:0], mosi_s};
  assign rx_word   = {rx_shift[DATA_W-2:0], mosi_s};
  assign hdr_last  = (state == HDR) && rise && (bit_cnt == CNT_W'(HDR_LEN-1));
  assign word_last = ((state == WDATA) || (state == RDATA)) && rise &&
                     (bit_cnt == CNT_W'(DATA_W-1));
  assign abort     = cs_s && (state inside {HDR, WDATA, RDATA}) &&
                     ((state == HDR) || (bit_cnt != '0));

  assign spi_miso_oe = (state == RDATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!cs_s) state_nxt = HDR;
      HDR:   if (hdr_last) state_nxt = hdr_word[ADDR_W] ? RDATA : WDATA;
`ifndef SPI_REG_BURST_EN
      WDATA: if (word_last) state_nxt = DONE;
      RDATA: if (word_last) state_nxt = DONE;
`endif
      default: state_nxt = state;
    endcase
    if (cs_s) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      rd_pend       <= 1'b0;
      spi_miso      <= 1'b0;
      frame_err     <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_write <= 1'b0;
      bus.reg_read  <= 1'b0;
    end else begin
      bus.reg_write <= 1'b0;
      bus.reg_read  <= 1'b0;
      frame_err     <= abort;
      rd_pend       <= bus.reg_read;

      if (cs_s) begin
        bit_cnt <= '0;
      end else if (rise && (state inside {HDR, WDATA, RDATA})) begin
        rx_shift <= {rx_shift[SH_W-2:0], mosi_s};
        bit_cnt  <= (hdr_last || word_last) ? '0 : bit_cnt + 1'b1;
      end

      if (hdr_last) begin
        bus.reg_addr <= hdr_word[ADDR_W-1:0];
        bus.reg_read <= hdr_word[ADDR_W];
      end

      if (word_last && (state == WDATA)) begin
        bus.reg_wdata <= rx_word;
        bus.reg_write <= 1'b1;
      end

`ifdef SPI_REG_BURST_EN
      // writes bump the address one cycle after the strobe so the strobe sees the old address
      if (bus.reg_write) bus.reg_addr <= bus.reg_addr + 1'b1;
      if (word_last && (state == RDATA)) begin
        bus.reg_addr <= bus.reg_addr + 1'b1;
        bus.reg_read <= 1'b1;
      end
`endif

      if (rd_pend)
        tx_shift <= bus.reg_rdata;
      else if (fall && (state == RDATA) && (bit_cnt != '0))
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

      spi_miso <= (state == RDATA) ? tx_shift[DATA_W-1] : 1'b0;
    end
  end
endmodule
